// File: rtl/mux_sel_pkg.sv
// Shared definitions for the registered N:1 channel selector: mode encodings,
// FSM state type and the select-width helper.
package mux_sel_pkg;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_OUT  = 1'b1
    } state_t;

    // Width of a channel index for n channels. Never less than one bit.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mux_n_1_scan_reg_onehot_decoder.sv
// One-hot decoder: idx -> N-bit one-hot vector. Indices >= N give all-zero.
module onehot_decoder #(
    parameter int N    = 4,
    parameter int SELW = 2
) (
    input  logic [SELW-1:0] idx,
    output logic [N-1:0]    onehot
);

    // Decode idx; out-of-range indices match no bit and leave the vector clear.
    always_comb begin
        onehot = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (idx == SELW'(k)) begin
                onehot[k] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_n_1_scan_reg.sv
// Registered N:1 channel selector with manual (single beat) and scan
// (channels 0..NCH-1, one beat per handshake) modes.
// Optional feature: define MUXSEL_PARITY_EN to add the registered y_par output.
module mux_n_1_scan_reg
    import mux_sel_pkg::*;
#(
    parameter int  NCH  = 4,
    parameter int  W    = 8,
    localparam int SELW = idx_width(NCH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NCH*W-1:0] d,
    input  logic [SELW-1:0]  sel,
    input  logic             mode,
    input  logic             start,
    input  logic             y_ready,
    output logic [W-1:0]     y,
    output logic             y_valid,
    output logic [SELW-1:0]  y_ch,
    output logic             y_last,
    output logic [NCH-1:0]   enable,
`ifdef MUXSEL_PARITY_EN
    output logic             busy,
    output logic             y_par
`else
    output logic             busy
`endif
);

    localparam logic [SELW-1:0] LAST_CH = SELW'(NCH - 1);

    state_t          state, state_n;
    logic            mode_q, mode_n;
    logic [SELW-1:0] ch, ch_n;
    logic            load;
    logic            done;
    logic            last_n;
    logic [W-1:0]    y_sel;
    logic [NCH-1:0]  enable_n;

    onehot_decoder #(
        .N    (NCH),
        .SELW (SELW)
    ) u_dec (
        .idx    (ch_n),
        .onehot (enable_n)
    );

    // State and latched mode register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            mode_q <= MODE_MANUAL;
        end else begin
            state  <= state_n;
            mode_q <= mode_n;
        end
    end

    // Next-state logic: load marks a new beat to capture, done ends the transfer.
    always_comb begin
        state_n = state;
        mode_n  = mode_q;
        ch_n    = ch;
        load    = 1'b0;
        done    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_n = ST_OUT;
                    mode_n  = mode;
                    ch_n    = (mode == MODE_SCAN) ? '0 : sel;
                    load    = 1'b1;
                end
            end
            ST_OUT: begin
                if (y_valid && y_ready) begin
                    if (mode_q == MODE_MANUAL || ch == LAST_CH) begin
                        state_n = ST_IDLE;
                        done    = 1'b1;
                    end else begin
                        ch_n = ch + SELW'(1);
                        load = 1'b1;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Channel data for the beat being loaded; out-of-range indices yield zero.
    always_comb begin
        y_sel = '0;
        for (int unsigned k = 0; k < NCH; k++) begin
            if (ch_n == SELW'(k)) begin
                y_sel = d[k*W +: W];
            end
        end
    end

    assign last_n = (mode_n == MODE_MANUAL) || (ch_n == LAST_CH);

    // Output beat registers: capture on load, hold under backpressure, clear flags on done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y       <= '0;
            y_valid <= 1'b0;
            ch      <= '0;
            y_last  <= 1'b0;
            enable  <= '0;
        end else if (load) begin
            y       <= y_sel;
            y_valid <= 1'b1;
            ch      <= ch_n;
            y_last  <= last_n;
            enable  <= enable_n;
        end else if (done) begin
            y_valid <= 1'b0;
            y_last  <= 1'b0;
            enable  <= '0;
        end
    end

`ifdef MUXSEL_PARITY_EN
    // Parity of the captured data, updated in step with y.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_par <= 1'b0;
        end else if (load) begin
            y_par <= ^y_sel;
        end
    end
`endif

    assign y_ch = ch;
    assign busy = (state == ST_OUT);

endmodule

// File: tb/tb_mux_n_1_scan_reg.sv
// Bench for mux_n_1_scan_reg (NCH=4 scoreboarded instance plus an NCH=3 instance).
// Honours MUXSEL_PARITY_EN when defined.
module tb_mux_n_1_scan_reg;

    typedef struct packed {
        logic [7:0] y;
        logic [1:0] ch;
        logic       last;
        logic [3:0] en;
    } exp_t;

    localparam logic [31:0] D_REF = {8'hD3, 8'hC2, 8'hB1, 8'hA0};

    logic        clk;
    logic        rst;
    logic [31:0] d;
    logic [1:0]  sel;
    logic        mode;
    logic        start;
    logic        y_ready;
    logic [7:0]  y;
    logic        y_valid;
    logic [1:0]  y_ch;
    logic        y_last;
    logic [3:0]  enable;
    logic        busy;

    logic [23:0] d3;
    logic [1:0]  sel3;
    logic        mode3;
    logic        start3;
    logic        y_ready3;
    logic [7:0]  y3;
    logic        y_valid3;
    logic [1:0]  y_ch3;
    logic        y_last3;
    logic [2:0]  enable3;
    logic        busy3;

`ifdef MUXSEL_PARITY_EN
    logic        y_par;
    logic        y_par3;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    exp_t q[$];

    mux_n_1_scan_reg #(.NCH(4), .W(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .d       (d),
        .sel     (sel),
        .mode    (mode),
        .start   (start),
        .y_ready (y_ready),
        .y       (y),
        .y_valid (y_valid),
        .y_ch    (y_ch),
        .y_last  (y_last),
        .enable  (enable),
`ifdef MUXSEL_PARITY_EN
        .busy    (busy),
        .y_par   (y_par)
`else
        .busy    (busy)
`endif
    );

    mux_n_1_scan_reg #(.NCH(3), .W(8)) dut3 (
        .clk     (clk),
        .rst     (rst),
        .d       (d3),
        .sel     (sel3),
        .mode    (mode3),
        .start   (start3),
        .y_ready (y_ready3),
        .y       (y3),
        .y_valid (y_valid3),
        .y_ch    (y_ch3),
        .y_last  (y_last3),
        .enable  (enable3),
`ifdef MUXSEL_PARITY_EN
        .busy    (busy3),
        .y_par   (y_par3)
`else
        .busy    (busy3)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (!busy) break;
            tick();
        end
        check("idle_after_transfer", 32'(busy), 32'd0);
    endtask

    // Monitor: every valid cycle is compared with the queue head; pop on handshake.
    always @(negedge clk) begin
        if (!rst && y_valid) begin
            n_checks++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_beat: got y=%0h ch=%0d, expected no beat", y, y_ch);
            end else begin
                check("beat_y", 32'(y), 32'(q[0].y));
                check("beat_ch", 32'(y_ch), 32'(q[0].ch));
                check("beat_last", 32'(y_last), 32'(q[0].last));
                check("beat_enable", 32'(enable), 32'(q[0].en));
                check("beat_busy", 32'(busy), 32'd1);
`ifdef MUXSEL_PARITY_EN
                check("beat_par", 32'(y_par), 32'(^q[0].y));
`endif
                if (y_ready) void'(q.pop_front());
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_y"}, 32'(y), 32'd0);
        check({tag, "_valid"}, 32'(y_valid), 32'd0);
        check({tag, "_ch"}, 32'(y_ch), 32'd0);
        check({tag, "_last"}, 32'(y_last), 32'd0);
        check({tag, "_enable"}, 32'(enable), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
`ifdef MUXSEL_PARITY_EN
        check({tag, "_par"}, 32'(y_par), 32'd0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; d = D_REF; sel = '0; mode = 1'b0; start = 1'b0; y_ready = 1'b0;
        d3 = {8'h33, 8'h22, 8'h11}; sel3 = '0; mode3 = 1'b0; start3 = 1'b0; y_ready3 = 1'b0;
        #2;
        check_reset_outputs("por");
        tick();
        rst = 1'b0;
        tick();

        // Manual select of channel 2 with two cycles of backpressure.
        sel = 2'd2; mode = 1'b0; start = 1'b1;
        q.push_back('{y: 8'hC2, ch: 2'd2, last: 1'b1, en: 4'b0100});
        tick();
        start = 1'b0;
        check("manual_latency_valid", 32'(y_valid), 32'd1);
        repeat (2) tick();
        y_ready = 1'b1;
        tick();
        y_ready = 1'b0;
        check("manual_done_valid", 32'(y_valid), 32'd0);
        check("manual_done_busy", 32'(busy), 32'd0);
        tick();

        // Reset mid-scan at channel 2.
        y_ready = 1'b1; mode = 1'b1; start = 1'b1;
        q.push_back('{y: 8'hA0, ch: 2'd0, last: 1'b0, en: 4'b0001});
        q.push_back('{y: 8'hB1, ch: 2'd1, last: 1'b0, en: 4'b0010});
        q.push_back('{y: 8'hC2, ch: 2'd2, last: 1'b0, en: 4'b0100});
        tick();
        start = 1'b0;
        repeat (2) tick();
        y_ready = 1'b0;
        check("prereset_ch", 32'(y_ch), 32'd2);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check_reset_outputs("midscan_rst");
        q.delete();
        tick();
        rst = 1'b0;
        tick();

        // Full scan with ready tied high: NCH consecutive beats.
        y_ready = 1'b1; mode = 1'b1; start = 1'b1;
        q.push_back('{y: 8'hA0, ch: 2'd0, last: 1'b0, en: 4'b0001});
        q.push_back('{y: 8'hB1, ch: 2'd1, last: 1'b0, en: 4'b0010});
        q.push_back('{y: 8'hC2, ch: 2'd2, last: 1'b0, en: 4'b0100});
        q.push_back('{y: 8'hD3, ch: 2'd3, last: 1'b1, en: 4'b1000});
        tick();
        start = 1'b0;
        check("scan_first_valid", 32'(y_valid), 32'd1);
        repeat (3) tick();
        check("scan_last_busy", 32'(busy), 32'd1);
        check("scan_last_ch", 32'(y_ch), 32'd3);
        tick();
        check("scan_end_busy", 32'(busy), 32'd0);
        check("scan_end_valid", 32'(y_valid), 32'd0);
        tick();

        // Scan with 3 cycles of backpressure at channel 1 while d changes.
        y_ready = 1'b1; mode = 1'b1; start = 1'b1;
        q.push_back('{y: 8'hA0, ch: 2'd0, last: 1'b0, en: 4'b0001});
        q.push_back('{y: 8'hB1, ch: 2'd1, last: 1'b0, en: 4'b0010});
        q.push_back('{y: 8'hC2, ch: 2'd2, last: 1'b0, en: 4'b0100});
        q.push_back('{y: 8'hD3, ch: 2'd3, last: 1'b1, en: 4'b1000});
        tick();
        start = 1'b0;
        tick();
        y_ready = 1'b0;
        d = 32'h5A5A_5A5A;
        repeat (3) tick();
        check("bp_hold_y", 32'(y), 32'hB1);
        d = D_REF;
        y_ready = 1'b1;
        wait_idle(10);
        tick();

        // Start pulses while busy are ignored; one manual beat on channel 1.
        y_ready = 1'b0; mode = 1'b0; sel = 2'd1; start = 1'b1;
        q.push_back('{y: 8'hB1, ch: 2'd1, last: 1'b1, en: 4'b0010});
        tick();
        mode = 1'b1; sel = 2'd3;
        repeat (3) tick();
        start = 1'b0;
        y_ready = 1'b1;
        tick();
        y_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("ignored_start_busy", 32'(busy), 32'd0);
            tick();
        end
        check("queue_drained", 32'(q.size()), 32'd0);

        // NCH=3: out-of-range manual select, then a short scan.
        start3 = 1'b1; mode3 = 1'b0; sel3 = 2'd3; y_ready3 = 1'b0;
        tick();
        start3 = 1'b0;
        check("oor_valid", 32'(y_valid3), 32'd1);
        check("oor_y", 32'(y3), 32'd0);
        check("oor_ch", 32'(y_ch3), 32'd3);
        check("oor_enable", 32'(enable3), 32'd0);
        check("oor_last", 32'(y_last3), 32'd1);
        y_ready3 = 1'b1;
        tick();
        check("oor_done_busy", 32'(busy3), 32'd0);
        start3 = 1'b1; mode3 = 1'b1;
        tick();
        start3 = 1'b0;
        check("n3_scan0_y", 32'(y3), 32'h11);
        check("n3_scan0_last", 32'(y_last3), 32'd0);
        tick();
        check("n3_scan1_y", 32'(y3), 32'h22);
        tick();
        check("n3_scan2_y", 32'(y3), 32'h33);
        check("n3_scan2_en", 32'(enable3), 32'b100);
        check("n3_scan2_last", 32'(y_last3), 32'd1);
`ifdef MUXSEL_PARITY_EN
        check("n3_scan2_par", 32'(y_par3), 32'd0);
`endif
        tick();
        check("n3_scan_end_busy", 32'(busy3), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
